prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a program over a byte stream, writes it into
// instruction memory one 32-bit word at a time, verifies an XOR checksum
// and then releases the core from reset.
//
// Stream: length N (16 bits, low byte first), N*4 data bytes (each word
// little-endian), one checksum byte (XOR of all data bytes).
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst        : synchronous active-low reset
//   start      : request a (re)load; honoured in IDLE, RUN and ERR only
//   byte_valid : byte_data carries a byte
//   byte_data  : program byte stream
//   byte_ready : loader takes a byte this cycle (valid & ready = transfer)
//   imem_we    : one-cycle write strobe per assembled word
//   imem_addr  : byte address of the word (word index * 4)
//   imem_wdata : assembled instruction word
//   core_rst   : active-low core reset, released only in RUN
//   done       : load finished with a matching checksum
//   error      : load aborted (bad length, bad checksum or timeout)
module prog_loader #(
  parameter int MAX_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam int WIDX_W = $clog2(MAX_WORDS + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN0  = 3'd1;
  localparam logic [2:0] LEN1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] CSUM  = 3'd5;
  localparam logic [2:0] RUN   = 3'd6;
  localparam logic [2:0] ERR   = 3'd7;

  logic [2:0]        state_reg, state_next;
  logic [15:0]       len_reg;
  logic [WIDX_W-1:0] word_index_reg;
  logic [1:0]        byte_cnt_reg;
  logic [23:0]       word_reg;      // lower three bytes; the fourth goes straight to imem_wdata
  logic [7:0]        csum_reg;
  logic [TO_W-1:0]   timeout_reg;

  logic        waiting;
  logic        timed_out;
  logic        accept;
  logic        start_load;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;

  // States in which the loader is waiting on the byte stream.
  assign waiting = (state_reg == LEN0) || (state_reg == LEN1) ||
                   (state_reg == DATA) || (state_reg == CSUM);
  assign timed_out = (timeout_reg == TO_W'(TIMEOUT_CYC));

  // Once the timeout has fired the pending byte is refused, so the abort
  // never swallows a byte.
  assign byte_ready = waiting && !timed_out;
  assign accept     = byte_ready && byte_valid;
  assign start_load = start && ((state_reg == IDLE) || (state_reg == RUN) ||
                                (state_reg == ERR));

  assign len_full  = {byte_data, len_reg[7:0]};
  assign len_bad   = (len_full == 16'd0) || ({16'd0, len_full} > 32'(MAX_WORDS));
  assign last_word = ((32'(word_index_reg) + 32'd1) == {16'd0, len_reg});

  assign imem_we  = (state_reg == WRITE);
  assign core_rst = (state_reg == RUN);
  assign done     = (state_reg == RUN);
  assign error    = (state_reg == ERR);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LEN0;
      LEN0: begin
        if (timed_out)   state_next = ERR;
        else if (accept) state_next = LEN1;
      end
      LEN1: begin
        if (timed_out)   state_next = ERR;
        else if (accept) state_next = len_bad ? ERR : DATA;
      end
      DATA: begin
        if (timed_out)                          state_next = ERR;
        else if (accept && byte_cnt_reg == 2'd3) state_next = WRITE;
      end
      WRITE: state_next = last_word ? CSUM : DATA;
      CSUM: begin
        if (timed_out)   state_next = ERR;
        else if (accept) state_next = (byte_data == csum_reg) ? RUN : ERR;
      end
      RUN, ERR: if (start) state_next = LEN0;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      word_index_reg <= '0;
      byte_cnt_reg   <= '0;
      csum_reg       <= '0;
      timeout_reg    <= '0;
      imem_addr      <= '0;
      imem_wdata     <= '0;
    end else begin
      state_reg <= state_next;

      if (start_load || accept)
        timeout_reg <= '0;
      else if (waiting && !timed_out)
        timeout_reg <= timeout_reg + TO_W'(1);

      if (start_load) begin
        word_index_reg <= '0;
        byte_cnt_reg   <= '0;
        csum_reg       <= '0;
      end

      if (accept && state_reg == LEN0) len_reg[7:0]  <= byte_data;
      if (accept && state_reg == LEN1) len_reg[15:8] <= byte_data;

      if (accept && state_reg == DATA) begin
        csum_reg     <= csum_reg ^ byte_data;
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        // Fourth byte: present the complete word for the WRITE cycle.
        if (byte_cnt_reg == 2'd3) begin
          imem_wdata <= {byte_data, word_reg};
          imem_addr  <= 32'(word_index_reg) << 2;
        end
      end

      if (state_reg == WRITE)
        word_index_reg <= word_index_reg + WIDX_W'(1);
    end
  end

  // Byte lanes 0..2 of the word being assembled, first byte in lane 0.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (!rst)
        word_reg[gi*8 +: 8] <= '0;
      else if (accept && state_reg == DATA && byte_cnt_reg == 2'(gi))
        word_reg[gi*8 +: 8] <= byte_data;
    end
  end

endmodule
